// File: rtl/fetch_req_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch request controller:
// default widths and the controller FSM state encoding.
package fetch_req_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Any flush source kills the fetch currently being sequenced.
  function automatic logic any_flush(input logic excep, input logic branch);
    return excep | branch;
  endfunction

endpackage

// File: rtl/fetch_req_ctrl_if.sv
// Bundle of the IF-side request/response, flush and inst_sram signals.
// Handshakes: a transfer happens in a cycle where valid (or req) and
// ready (or addr_ok) are both high; the requester holds its payload
// stable and never drops valid/req until that transfer cycle.
// master = fetch controller, slave = IF stage / SRAM environment.
interface fetch_req_ctrl_if
  import fetch_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req_valid_i;
  logic [ADDR_W-1:0] if_req_addr_i;
  logic              if_req_ready_o;
  logic              excep_flush_i;
  logic              branch_flush_i;
  logic              inst_sram_req_o;
  logic [ADDR_W-1:0] inst_sram_addr_o;
  logic              inst_sram_addr_ok_i;
  logic              inst_sram_data_ok_i;
  logic [DATA_W-1:0] inst_sram_rdata_i;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_ready_i;
  logic              busy_o;

  modport master (
    input  if_req_valid_i, if_req_addr_i, excep_flush_i, branch_flush_i,
    input  inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_sram_rdata_i,
    input  resp_ready_i,
    output if_req_ready_o, inst_sram_req_o, inst_sram_addr_o,
    output resp_valid_o, resp_data_o, busy_o
  );

  modport slave (
    output if_req_valid_i, if_req_addr_i, excep_flush_i, branch_flush_i,
    output inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_sram_rdata_i,
    output resp_ready_i,
    input  if_req_ready_o, inst_sram_req_o, inst_sram_addr_o,
    input  resp_valid_o, resp_data_o, busy_o
  );

endinterface

// File: rtl/fetch_cancel_cnt.sv
// Saturating up/down counter of cancelled requests whose data_ok is
// still to come. Simultaneous inc and dec cancel each other out.
module fetch_cancel_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  // Count register; holds at the rails instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full = &cnt;
  assign zero = ~|cnt;

endmodule

// File: rtl/fetch_req_ctrl.sv
// IF-stage fetch request controller: one inst_sram request at a time,
// returns data to IF, and discards responses of flushed requests via
// the cancel counter.
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_req_ctrl_if.master      bus,
  output fetch_state_e          dbg_state_o
);

  fetch_state_e      state, state_next;
  logic              kill_q, kill_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] buf_q;
  logic              flush;
  logic              accept;
  logic              cnt_inc, cnt_dec, cnt_full, cnt_zero;
  logic              live_data;

  assign flush     = any_flush(bus.excep_flush_i, bus.branch_flush_i);
  assign accept    = bus.if_req_valid_i && bus.if_req_ready_o && !flush;
  // Any data_ok while cancelled responses are owed belongs to one of them.
  assign cnt_dec   = bus.inst_sram_data_ok_i && !cnt_zero;
  // Data for the fetch being waited on (no cancelled ones ahead of it).
  assign live_data = (state == ST_WAIT) && bus.inst_sram_data_ok_i && cnt_zero;

  fetch_cancel_cnt #(.CNT_W(CNT_W)) u_cancel_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .dec  (cnt_dec),
    .full (cnt_full),
    .zero (cnt_zero)
  );

  // State and kill registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      kill_q <= 1'b0;
    end else begin
      state  <= state_next;
      kill_q <= kill_next;
    end
  end

  // Next-state logic; also decides when an in-flight request is cancelled.
  always_comb begin
    state_next = state;
    kill_next  = kill_q;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_REQ;
      end
      ST_REQ: begin
        // The request stays up until addr_ok; a flush only marks it dead.
        if (bus.inst_sram_addr_ok_i) begin
          if (kill_q || flush) begin
            cnt_inc    = 1'b1;
            kill_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end else if (flush) begin
          kill_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (live_data) begin
          state_next = (flush || bus.resp_ready_i) ? ST_IDLE : ST_HOLD;
        end else if (flush) begin
          // Our data is still owed; if a cancelled data_ok arrives in the
          // same cycle the counter's inc and dec net out.
          cnt_inc    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (flush || bus.resp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address latch and response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      buf_q  <= '0;
    end else begin
      if (accept) addr_q <= bus.if_req_addr_i;
      if (live_data && !flush && !bus.resp_ready_i) buf_q <= bus.inst_sram_rdata_i;
    end
  end

  // Outputs decoded from state; response is never valid under a flush.
  always_comb begin
    bus.if_req_ready_o  = (state == ST_IDLE) && !cnt_full;
    bus.inst_sram_req_o = (state == ST_REQ);
    bus.resp_valid_o    = 1'b0;
    bus.resp_data_o     = buf_q;
    case (state)
      ST_WAIT: begin
        bus.resp_valid_o = live_data && !flush;
        bus.resp_data_o  = bus.inst_sram_rdata_i;
      end
      ST_HOLD: bus.resp_valid_o = !flush;
      default: ;
    endcase
  end

  assign bus.inst_sram_addr_o = addr_q;
  assign bus.busy_o           = (state != ST_IDLE) || !cnt_zero;
  assign dbg_state_o          = state;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Bench for fetch_req_ctrl. The reference model tracks fetches as
// transactions: the one awaiting addr_ok, a queue of requests awaiting
// data_ok (each alive or dead), and a response held for IF. Any flush
// kills every in-flight fetch; only live data reaches IF.
module tb_fetch_req_ctrl;
  import fetch_req_ctrl_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int MAX_CANCEL = 3;

  logic clk;
  logic rst;
  fetch_state_e dbg_state;

  fetch_req_ctrl_if bus ();

  fetch_req_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  bit                req_pending;   // accepted, waiting for addr_ok
  bit                req_live;      // no flush since acceptance
  logic [ADDR_W-1:0] req_addr;
  bit                live_q[$];     // requests past addr_ok, oldest first
  bit                hold;          // response shown to IF, not yet taken
  logic [DATA_W-1:0] exp_q[$];      // data of the held response

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    req_pending = 0;
    req_live    = 0;
    hold        = 0;
    live_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.if_req_valid_i      = 1'b0;
    bus.if_req_addr_i       = '0;
    bus.excep_flush_i       = 1'b0;
    bus.branch_flush_i      = 1'b0;
    bus.inst_sram_addr_ok_i = 1'b0;
    bus.inst_sram_data_ok_i = 1'b0;
    bus.inst_sram_rdata_i   = '0;
    bus.resp_ready_i        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    check("rst_ready", 64'(bus.if_req_ready_o), 64'(1'b1));
    check("rst_req",   64'(bus.inst_sram_req_o), 64'(1'b0));
    check("rst_valid", 64'(bus.resp_valid_o), 64'(1'b0));
    check("rst_busy",  64'(bus.busy_o), 64'(1'b0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input logic v, input logic [ADDR_W-1:0] a,
                      input logic ef, input logic bf,
                      input logic aok, input logic dok,
                      input logic [DATA_W-1:0] rd, input logic rr);
    logic              fl, e_ready, e_valid, live_any, e_busy;
    logic [DATA_W-1:0] e_data;
    int                dead;
    fetch_state_e      e_state;
    bus.if_req_valid_i      = v;
    bus.if_req_addr_i       = a;
    bus.excep_flush_i       = ef;
    bus.branch_flush_i      = bf;
    bus.inst_sram_addr_ok_i = aok;
    bus.inst_sram_data_ok_i = dok;
    bus.inst_sram_rdata_i   = rd;
    bus.resp_ready_i        = rr;
    #2;
    fl       = ef | bf;
    dead     = 0;
    live_any = 0;
    foreach (live_q[i]) begin
      if (live_q[i]) live_any = 1;
      else dead++;
    end
    e_ready = !req_pending && !live_any && !hold && (dead < MAX_CANCEL);
    e_busy  = req_pending || hold || (live_q.size() > 0);
    e_valid = 0;
    e_data  = '0;
    if (hold && !fl) begin
      e_valid = 1;
      e_data  = exp_q[0];
    end else if (!hold && dok && live_q.size() > 0 && live_q[0] && !fl) begin
      e_valid = 1;
      e_data  = rd;
    end
    if (req_pending)   e_state = ST_REQ;
    else if (hold)     e_state = ST_HOLD;
    else if (live_any) e_state = ST_WAIT;
    else               e_state = ST_IDLE;

    check("if_req_ready", 64'(bus.if_req_ready_o), 64'(e_ready));
    check("sram_req",     64'(bus.inst_sram_req_o), 64'(req_pending));
    if (req_pending) check("sram_addr", 64'(bus.inst_sram_addr_o), 64'(req_addr));
    check("resp_valid",   64'(bus.resp_valid_o), 64'(e_valid));
    if (e_valid) check("resp_data", bus.resp_data_o, e_data);
    check("busy",         64'(bus.busy_o), 64'(e_busy));
    check("state",        64'(dbg_state), 64'(e_state));

    // Advance the model by this cycle's events.
    if (dok && live_q.size() > 0) void'(live_q.pop_front());
    if (hold) begin
      if (fl || rr) begin
        hold = 0;
        exp_q.delete();
      end
    end else if (e_valid && !rr) begin
      hold = 1;
      exp_q.push_back(rd);
    end
    if (fl) begin
      foreach (live_q[i]) live_q[i] = 0;
      req_live = 0;
    end
    if (req_pending && aok) begin
      live_q.push_back(req_live);
      req_pending = 0;
    end
    if (v && e_ready && !fl) begin
      req_pending = 1;
      req_live    = 1;
      req_addr    = a;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, '0, 0, 0, 0, 0, '0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] rd;
    rst = 1'b1;
    drive_idle();
    do_reset();

    // Normal fetch: addr_ok on the second request cycle, data 3 cycles later.
    step(1, 32'h1c000000, 0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 1, 0, '0, 1);
    nop();
    nop();
    step(0, '0, 0, 0, 0, 1, 64'h02800000_1c000000, 1);
    nop();

    // Backpressure: response held 4 cycles, taken on the 5th.
    step(1, 32'h1c000008, 0, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 1, 0, '0, 0);
    step(0, '0, 0, 0, 0, 1, 64'h0badf00d_12345678, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 0, 0, '0, 1);
    nop();

    // Branch flush while waiting for data, then a new fetch.
    step(1, 32'h1c000010, 0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 1, 0, '0, 1);
    step(0, '0, 0, 1, 0, 0, '0, 1);
    step(1, 32'h1c000100, 0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 1, 0, '0, 1);
    step(0, '0, 0, 0, 0, 1, 64'hdeaddead_deaddead, 1);
    step(0, '0, 0, 0, 0, 1, 64'h00000100_1c000100, 1);
    nop();

    // Exception flush while the request waits for addr_ok.
    step(1, 32'h1c000200, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 1, 0, '0, 1);
    step(0, '0, 0, 0, 0, 1, 64'h11111111_22222222, 1);
    nop();

    // Saturation: three cancelled requests block new fetches.
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h1c000300 + 32'(i * 8), 0, 0, 0, 0, '0, 1);
      step(0, '0, 0, 1, 1, 0, '0, 1);
    end
    step(1, 32'h1c000400, 0, 0, 0, 0, '0, 1);
    step(1, 32'h1c000400, 0, 0, 0, 1, 64'h1, 1);
    step(1, 32'h1c000400, 0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 1, 0, '0, 1);
    step(0, '0, 0, 0, 0, 1, 64'h2, 1);
    step(0, '0, 0, 0, 0, 1, 64'h3, 1);
    step(0, '0, 0, 0, 0, 1, 64'h44444444_1c000400, 1);
    nop();

    // Reset while waiting for data with two cancelled responses owed.
    for (int i = 0; i < 2; i++) begin
      step(1, 32'h1c000500 + 32'(i * 8), 0, 0, 0, 0, '0, 1);
      step(0, '0, 0, 1, 1, 0, '0, 1);
    end
    step(1, 32'h1c000600, 0, 0, 0, 0, '0, 1);
    step(0, '0, 0, 0, 1, 0, '0, 1);
    do_reset();

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 3000; n++) begin
      logic v, ef, bf, aok, dok, rr;
      logic [ADDR_W-1:0] a;
      v   = 1'($urandom_range(0, 1));
      a   = $urandom() & 32'hffff_fffc;
      ef  = ($urandom_range(0, 19) == 0);
      bf  = ($urandom_range(0, 13) == 0);
      aok = ($urandom_range(0, 2) == 0);
      dok = (live_q.size() > 0) && ($urandom_range(0, 2) == 0);
      rd  = {$urandom(), $urandom()};
      rr  = ($urandom_range(0, 3) != 0);
      step(v, a, ef, bf, aok, dok, rd, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
